plab4_net_ring_route_pipe: RTL and testbench
============================================

// Module: plab4_net_ring_route_pipe
// PURPOSE
//  Registered route-compute stage for the ring router input path; sits between input queue and switch arbiter.
//  Accepts a val/rdy message, extracts its destination field and picks a direction: PREV, NEXT or TERM.
//  Queues message, route and domain in a 2-entry buffer; any ring size is supported (not only powers of two).
//  Selectable tie policy with per-domain tie-break state, so one domain's traffic never alters another's routes.
// PARAMETERS
//  p_router_id    0   this router's ring position, 0..p_num_routers-1
//  p_num_routers  8   ring size N, >=2, any integer
//  p_msg_nbits    44  message width
//  p_dest_lsb     33  lsb of dest field inside msg; field is c_dest_nbits wide
//  p_tie_mode     1   0: tie->PREV; 1: tie alternates NEXT/PREV per domain; 2: tie->NEXT
//  c_dest_nbits   $clog2(p_num_routers)  derived; not set outside
// PORTS
//  clk         in   1               clock
//  reset       in   1               synchronous, active-high
//  in_domain   in   1   {L}         security domain of in_msg
//  in_val      in   1   {L}         input message valid
//  in_rdy      out  1   {L}         stage can accept
//  in_msg      in   p_msg_nbits     {Domain in_domain} message
//  out_domain  out  1   {L}         domain of head entry
//  out_val     out  1   {L}         head entry valid
//  out_rdy     in   1   {L}         downstream accepts head
//  out_msg     out  p_msg_nbits     {Domain out_domain} head message
//  out_route   out  2               {Domain out_domain} ROUTE_PREV=00, ROUTE_NEXT=01, ROUTE_TERM=10
//  out_err     out  1               {Domain out_domain} dest >= N
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous, active-high, on reset. Reset: count=0, out_val=0, in_rdy=1,
//    tie toggles=0, out_err=0; out_msg/out_route/out_domain read 0.
//  - Buffer: 2-entry FIFO holding {domain,msg,route,err}. in_rdy=(count!=2), out_val=(count!=0).
//  - enq = in_val&in_rdy, deq = out_val&out_rdy. Both in one cycle: count unchanged, order kept.
//  - Latency 1 cycle: entry enqueued at edge t is visible at out_* from t+1. No combinational in->out bypass.
//  - Route computed at enqueue from in_msg dest d, using (c_dest_nbits+1)-bit math:
//    fwd = (d - id) mod N; bwd = (id - d) mod N; mod done by adding N on borrow.
//    d==id -> TERM; fwd<bwd -> NEXT; fwd>bwd -> PREV; fwd==bwd (N even, d opposite) -> tie policy.
//  - Tie mode 1: toggle[in_domain]=0 -> NEXT, else PREV; toggle[in_domain] flips only on an accepted
//    tie enqueue. The other domain's toggle is untouched.
//  - d >= N (only when N is not a power of 2): route=TERM, err=1, toggles untouched, message still queued.
//  - Full: in_rdy=0; no enqueue and no state change from in_* that cycle.
//  - Empty with out_rdy=1: no dequeue, count stays 0.
//  - Reset mid-operation: buffered entries dropped, toggles cleared; reset wins over simultaneous enq/deq.
//  - Pointers wrap mod 2; count never exceeds 2 or goes below 0 (assertion in sim).
//  - in_rdy and out_val depend only on count ({L}); route/err values never affect handshake timing.
// STRUCTURE
//  - Shared include plab4-net-RouteConsts: ROUTE_PREV/NEXT/TERM macros, TIE_MODE_* constants.
//    Reused by all ring router variants.
//  - Sub-module plab4_net_ring_route_calc: combinational (dest, domain toggle) -> (route, err, is_tie).
//    Carries the same domain labelling.
//  - Top level holds the 2-entry buffer, count/pointers and the two tie toggles.
// TESTING
//  T1 N=8,id=2,mode1: dest 2 -> TERM; dest 5 -> NEXT; dest 7 -> PREV.
//     out_val rises 1 cycle after each enqueue.
//  T2 N=8,id=2,mode1: dest 6 four times, domain 0 -> NEXT,PREV,NEXT,PREV.
//     Interleave with domain 1 dest 6 -> domain 1 starts at NEXT, independent of domain 0.
//  T3 N=5,id=4: dest 0 -> NEXT (fwd1,bwd4); dest 2 -> PREV (fwd3,bwd2); dest 6 -> TERM, out_err=1.
//  T4 out_rdy=0, offer msgs A,B,C back-to-back -> in_rdy=0 after A,B enqueue.
//     Release out_rdy -> out order A,B,C; with in_val and out_rdy both high, 1 msg/cycle throughput.
//  T5 two entries queued, toggle[0]=1; assert reset 1 cycle -> next cycle out_val=0, in_rdy=1.
//     Next tie for domain 0 -> NEXT.
//  T6 mode 0 and mode 2, N=8,id=0,dest 4 -> PREV and NEXT respectively; toggles never change.

Source files
------------

// File: rtl/plab4_net_ring_route_pipe_pkg.sv
// Shared route encodings and tie-policy selectors for the ring router variants.
package plab4_net_ring_route_pipe_pkg;

   typedef enum logic [1:0] {
      ROUTE_PREV = 2'b00,
      ROUTE_NEXT = 2'b01,
      ROUTE_TERM = 2'b10
   } route_e;

   localparam int TIE_MODE_PREV = 0;
   localparam int TIE_MODE_ALT  = 1;
   localparam int TIE_MODE_NEXT = 2;

endpackage

// File: rtl/plab4_net_ring_route_calc.sv
// Combinational route decision for one destination; inputs and outputs all belong to
// the security domain of the message being routed.
module plab4_net_ring_route_calc
   import plab4_net_ring_route_pipe_pkg::*;
#(
   parameter  int p_router_id   = 0,
   parameter  int p_num_routers = 8,
   parameter  int p_tie_mode    = 1,
   localparam int c_dest_nbits  = $clog2(p_num_routers)
)(
   input  logic [c_dest_nbits-1:0] dest_i,
   input  logic                    toggle_i,
   output logic [1:0]              route_o,
   output logic                    err_o,
   output logic                    is_tie_o
);

   // One extra bit so that adding N back after a borrow cannot overflow.
   localparam int W = c_dest_nbits + 1;
   localparam logic [W-1:0] c_n  = W'(p_num_routers);
   localparam logic [W-1:0] c_id = W'(p_router_id);

   logic [W-1:0] d_ext;
   logic [W-1:0] fwd;
   logic [W-1:0] bwd;

   always_comb begin
      d_ext    = {1'b0, dest_i};
      fwd      = (d_ext < c_id) ? (d_ext - c_id + c_n) : (d_ext - c_id);
      bwd      = (c_id < d_ext) ? (c_id - d_ext + c_n) : (c_id - d_ext);
      err_o    = (d_ext >= c_n);
      is_tie_o = 1'b0;
      route_o  = ROUTE_TERM;
      if (err_o || (d_ext == c_id)) begin
         route_o = ROUTE_TERM;
      end else if (fwd < bwd) begin
         route_o = ROUTE_NEXT;
      end else if (fwd > bwd) begin
         route_o = ROUTE_PREV;
      end else begin
         is_tie_o = 1'b1;
         if (p_tie_mode == TIE_MODE_PREV)      route_o = ROUTE_PREV;
         else if (p_tie_mode == TIE_MODE_NEXT) route_o = ROUTE_NEXT;
         else                                  route_o = toggle_i ? ROUTE_PREV : ROUTE_NEXT;
      end
   end

endmodule

// File: rtl/plab4_net_ring_route_pipe.sv
// Registered route-compute stage: computes a ring direction at enqueue and holds
// {domain, msg, route, err} in a 2-entry FIFO with per-domain tie-break toggles.
module plab4_net_ring_route_pipe
   import plab4_net_ring_route_pipe_pkg::*;
#(
   parameter int p_router_id   = 0,
   parameter int p_num_routers = 8,
   parameter int p_msg_nbits   = 44,
   parameter int p_dest_lsb    = 33,
   parameter int p_tie_mode    = 1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_domain,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [p_msg_nbits-1:0] in_msg,
   output logic                   out_domain,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [p_msg_nbits-1:0] out_msg,
   output logic [1:0]             out_route,
   output logic                   out_err
);

   localparam int c_dest_nbits = $clog2(p_num_routers);

   typedef struct packed {
      logic                   domain;
      logic [p_msg_nbits-1:0] msg;
      logic [1:0]             route;
      logic                   err;
   } entry_t;

   entry_t     ent_q [2];
   entry_t     new_ent;
   entry_t     head;
   logic [1:0] count_q, count_d;
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] tog_q, tog_d;
   logic       enq, deq;
   logic [1:0] calc_route;
   logic       calc_err;
   logic       calc_tie;

   plab4_net_ring_route_calc #(
      .p_router_id   (p_router_id),
      .p_num_routers (p_num_routers),
      .p_tie_mode    (p_tie_mode)
   ) u_calc (
      .dest_i   (in_msg[p_dest_lsb +: c_dest_nbits]),
      .toggle_i (tog_q[in_domain]),
      .route_o  (calc_route),
      .err_o    (calc_err),
      .is_tie_o (calc_tie)
   );

   // Handshake depends on occupancy only, never on message contents.
   assign in_rdy  = (count_q != 2'd2);
   assign out_val = (count_q != 2'd0);
   assign enq     = in_val & in_rdy;
   assign deq     = out_val & out_rdy;

   always_comb begin
      count_d = count_q;
      if (enq && !deq)      count_d = count_q + 2'd1;
      else if (deq && !enq) count_d = count_q - 2'd1;

      tog_d = tog_q;
      if (enq && calc_tie && (p_tie_mode == TIE_MODE_ALT))
         tog_d[in_domain] = ~tog_q[in_domain];

      new_ent = '{domain: in_domain, msg: in_msg, route: calc_route, err: calc_err};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         tog_q    <= 2'b00;
      end else begin
         count_q  <= count_d;
         tog_q    <= tog_d;
         if (enq) wr_ptr_q <= ~wr_ptr_q;
         if (deq) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) ent_q[wr_ptr_q] <= new_ent;
   end

   // Stale storage is masked so an empty stage always presents zeros.
   assign head       = ent_q[rd_ptr_q];
   assign out_domain = out_val ? head.domain : 1'b0;
   assign out_msg    = out_val ? head.msg    : '0;
   assign out_route  = out_val ? head.route  : 2'b00;
   assign out_err    = out_val ? head.err    : 1'b0;

   always_ff @(posedge clk) begin
      if (!reset) assert (count_q <= 2'd2);
   end

endmodule

// File: tb/tb_plab4_net_ring_route_pipe.sv
// Bench driving four differently configured route stages with identical stimulus,
// each checked against a queue-based reference model of the routing rules.
module tb_plab4_net_ring_route_pipe;
   import plab4_net_ring_route_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_domain = 1'b0;
   logic        in_val = 1'b0;
   logic [43:0] in_msg = '0;
   logic        out_rdy = 1'b0;

   logic        in_rdy_w     [4];
   logic        out_val_w    [4];
   logic        out_domain_w [4];
   logic [43:0] out_msg_w    [4];
   logic [1:0]  out_route_w  [4];
   logic        out_err_w    [4];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   plab4_net_ring_route_pipe #(.p_router_id(2), .p_num_routers(8), .p_tie_mode(1)) dut0 (
      .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy_w[0]),
      .in_msg(in_msg), .out_domain(out_domain_w[0]), .out_val(out_val_w[0]), .out_rdy(out_rdy),
      .out_msg(out_msg_w[0]), .out_route(out_route_w[0]), .out_err(out_err_w[0]));
   plab4_net_ring_route_pipe #(.p_router_id(4), .p_num_routers(5), .p_tie_mode(1)) dut1 (
      .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy_w[1]),
      .in_msg(in_msg), .out_domain(out_domain_w[1]), .out_val(out_val_w[1]), .out_rdy(out_rdy),
      .out_msg(out_msg_w[1]), .out_route(out_route_w[1]), .out_err(out_err_w[1]));
   plab4_net_ring_route_pipe #(.p_router_id(0), .p_num_routers(8), .p_tie_mode(0)) dut2 (
      .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy_w[2]),
      .in_msg(in_msg), .out_domain(out_domain_w[2]), .out_val(out_val_w[2]), .out_rdy(out_rdy),
      .out_msg(out_msg_w[2]), .out_route(out_route_w[2]), .out_err(out_err_w[2]));
   plab4_net_ring_route_pipe #(.p_router_id(0), .p_num_routers(8), .p_tie_mode(2)) dut3 (
      .clk(clk), .reset(reset), .in_domain(in_domain), .in_val(in_val), .in_rdy(in_rdy_w[3]),
      .in_msg(in_msg), .out_domain(out_domain_w[3]), .out_val(out_val_w[3]), .out_rdy(out_rdy),
      .out_msg(out_msg_w[3]), .out_route(out_route_w[3]), .out_err(out_err_w[3]));

   // Reference model: FIFO of accepted messages, each with the route every instance should give.
   typedef struct packed {
      logic [43:0]     msg;
      logic            dom;
      logic [3:0][1:0] route;
      logic [3:0]      err;
   } ent_t;

   ent_t mq[$];
   int   tog [4][2];

   function automatic int cfg_n(int k);    return (k == 1) ? 5 : 8; endfunction
   function automatic int cfg_id(int k);   return (k == 0) ? 2 : (k == 1) ? 4 : 0; endfunction
   function automatic int cfg_mode(int k); return (k == 2) ? 0 : (k == 3) ? 2 : 1; endfunction

   function automatic bit ref_tie(int k, int d);
      int n, id;
      n  = cfg_n(k);
      id = cfg_id(k);
      if (d >= n || d == id) return 1'b0;
      return ((d - id + n) % n) == ((id - d + n) % n);
   endfunction

   function automatic logic [2:0] ref_route(int k, int d, int dom);
      int n, id, fwd, bwd;
      n  = cfg_n(k);
      id = cfg_id(k);
      if (d >= n) return {1'b1, ROUTE_TERM};
      if (d == id) return {1'b0, ROUTE_TERM};
      fwd = (d - id + n) % n;
      bwd = (id - d + n) % n;
      if (fwd < bwd) return {1'b0, ROUTE_NEXT};
      if (fwd > bwd) return {1'b0, ROUTE_PREV};
      if (cfg_mode(k) == 0) return {1'b0, ROUTE_PREV};
      if (cfg_mode(k) == 2) return {1'b0, ROUTE_NEXT};
      return (tog[k][dom] != 0) ? {1'b0, ROUTE_PREV} : {1'b0, ROUTE_NEXT};
   endfunction

   function automatic logic [43:0] mk_msg(int d);
      logic [43:0] m;
      m = {12'($urandom), 32'($urandom)};
      m[35:33] = 3'(d);
      return m;
   endfunction

   // Drives one clock of stimulus and advances the model; outputs are sampled 1ns after the edge.
   task automatic cycle(input logic v, input logic [43:0] m, input logic dom,
                        input logic ordy, input logic rst);
      bit   enq, deq;
      int   d;
      ent_t e;
      in_val = v; in_msg = m; in_domain = dom; out_rdy = ordy; reset = rst;
      enq = v && (mq.size() < 2);
      deq = (mq.size() > 0) && ordy;
      d   = int'(m[35:33]);
      e.msg = m;
      e.dom = dom;
      for (int k = 0; k < 4; k++) {e.err[k], e.route[k]} = ref_route(k, d, int'(dom));
      @(posedge clk);
      if (rst) begin
         mq.delete();
         for (int k = 0; k < 4; k++) begin tog[k][0] = 0; tog[k][1] = 0; end
      end else begin
         if (deq) void'(mq.pop_front());
         if (enq) begin
            for (int k = 0; k < 4; k++)
               if (ref_tie(k, d) && cfg_mode(k) == 1) tog[k][dom] = 1 - tog[k][dom];
            mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, mk_msg(3), 1'b1, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_val_w[k] !== 1'b0) begin failures++; $display("FAIL reset_out_val k=%0d got=%b exp=0", k, out_val_w[k]); end
         checks++; if (in_rdy_w[k] !== 1'b1) begin failures++; $display("FAIL reset_in_rdy k=%0d got=%b exp=1", k, in_rdy_w[k]); end
         checks++; if ({out_domain_w[k], out_msg_w[k], out_route_w[k], out_err_w[k]} !== 48'h0) begin
            failures++; $display("FAIL reset_outputs k=%0d got dom=%b msg=%h route=%b err=%b exp all zero",
                                 k, out_domain_w[k], out_msg_w[k], out_route_w[k], out_err_w[k]);
         end
      end
   endtask

   task automatic test_route();
      int         rk [8] = '{0, 0, 0, 1, 1, 1, 2, 3};
      int         rd [8] = '{2, 5, 7, 0, 2, 6, 4, 4};
      logic [1:0] rr [8] = '{ROUTE_TERM, ROUTE_NEXT, ROUTE_PREV, ROUTE_NEXT, ROUTE_PREV, ROUTE_TERM, ROUTE_PREV, ROUTE_NEXT};
      logic       re [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, mk_msg(rd[i]), 1'b0, 1'b0, 1'b0);
         checks++; if (out_val_w[rk[i]] !== 1'b1) begin failures++; $display("FAIL route_latency row=%0d got=%b exp=1", i, out_val_w[rk[i]]); end
         checks++; if (out_route_w[rk[i]] !== rr[i]) begin failures++; $display("FAIL route_dir row=%0d k=%0d dest=%0d got=%b exp=%b", i, rk[i], rd[i], out_route_w[rk[i]], rr[i]); end
         checks++; if (out_err_w[rk[i]] !== re[i]) begin failures++; $display("FAIL route_err row=%0d got=%b exp=%b", i, out_err_w[rk[i]], re[i]); end
         for (int k = 0; k < 4; k++) begin
            checks++; if ({out_route_w[k], out_err_w[k]} !== {mq[0].route[k], mq[0].err[k]}) begin
               failures++; $display("FAIL route_model row=%0d k=%0d got=%b/%b exp=%b/%b", i, k, out_route_w[k], out_err_w[k], mq[0].route[k], mq[0].err[k]);
            end
         end
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
         checks++; if (out_val_w[0] !== 1'b0) begin failures++; $display("FAIL route_drain row=%0d got=%b exp=0", i, out_val_w[0]); end
      end
   endtask

   task automatic test_tie_domains();
      logic       doms [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0] exp  [6] = '{ROUTE_NEXT, ROUTE_NEXT, ROUTE_PREV, ROUTE_PREV, ROUTE_NEXT, ROUTE_PREV};
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, mk_msg(6), doms[i], 1'b0, 1'b0);
         checks++; if (out_route_w[0] !== exp[i]) begin failures++; $display("FAIL tie_alt step=%0d dom=%b got=%b exp=%b", i, doms[i], out_route_w[0], exp[i]); end
         checks++; if (out_domain_w[0] !== doms[i]) begin failures++; $display("FAIL tie_domain step=%0d got=%b exp=%b", i, out_domain_w[0], doms[i]); end
         checks++; if (out_route_w[0] !== mq[0].route[0]) begin failures++; $display("FAIL tie_model step=%0d got=%b exp=%b", i, out_route_w[0], mq[0].route[0]); end
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_fixed_tie();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, mk_msg(4), 1'(i), 1'b0, 1'b0);
         checks++; if (out_route_w[2] !== ROUTE_PREV) begin failures++; $display("FAIL tie_mode0 step=%0d got=%b exp=%b", i, out_route_w[2], ROUTE_PREV); end
         checks++; if (out_route_w[3] !== ROUTE_NEXT) begin failures++; $display("FAIL tie_mode2 step=%0d got=%b exp=%b", i, out_route_w[3], ROUTE_NEXT); end
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [43:0] m [5];
      int          stim [8] = '{0, 1, 2, 2, 2, 3, 4, 0};
      logic        vals [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        rdys [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int          head [8] = '{0, 0, 0, 1, 2, 3, 4, -1};
      logic        irdy [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) m[i] = mk_msg(int'($urandom_range(0, 7)));
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle(vals[i], m[stim[i]], 1'b1, rdys[i], 1'b0);
         for (int k = 0; k < 4; k++) begin
            checks++; if (in_rdy_w[k] !== irdy[i]) begin failures++; $display("FAIL b2b_in_rdy step=%0d k=%0d got=%b exp=%b", i, k, in_rdy_w[k], irdy[i]); end
            checks++; if (out_val_w[k] !== (head[i] >= 0)) begin failures++; $display("FAIL b2b_out_val step=%0d k=%0d got=%b exp=%b", i, k, out_val_w[k], head[i] >= 0); end
            if (head[i] >= 0) begin
               checks++; if (out_msg_w[k] !== m[head[i]]) begin failures++; $display("FAIL b2b_order step=%0d k=%0d got=%h exp=%h", i, k, out_msg_w[k], m[head[i]]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, mk_msg(6), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, mk_msg(5), 1'b1, 1'b0, 1'b0);
      checks++; if (in_rdy_w[0] !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b exp=0", in_rdy_w[0]); end
      cycle(1'b1, mk_msg(6), 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_val_w[k] !== 1'b0) begin failures++; $display("FAIL midrst_out_val k=%0d got=%b exp=0", k, out_val_w[k]); end
         checks++; if (in_rdy_w[k] !== 1'b1) begin failures++; $display("FAIL midrst_in_rdy k=%0d got=%b exp=1", k, in_rdy_w[k]); end
      end
      cycle(1'b1, mk_msg(6), 1'b0, 1'b0, 1'b0);
      checks++; if (out_route_w[0] !== ROUTE_NEXT) begin failures++; $display("FAIL midrst_tie got=%b exp=%b", out_route_w[0], ROUTE_NEXT); end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic v, dom, ordy, rst;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         v    = 1'($urandom_range(0, 3) != 0);
         dom  = 1'($urandom);
         ordy = 1'($urandom_range(0, 2) != 0);
         rst  = ($urandom_range(0, 59) == 0);
         cycle(v, mk_msg(int'($urandom_range(0, 7))), dom, ordy, rst);
         for (int k = 0; k < 4; k++) begin
            checks++; if (out_val_w[k] !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_out_val i=%0d k=%0d got=%b exp=%b", i, k, out_val_w[k], mq.size() != 0); end
            checks++; if (in_rdy_w[k] !== (mq.size() != 2)) begin failures++; $display("FAIL rnd_in_rdy i=%0d k=%0d got=%b exp=%b", i, k, in_rdy_w[k], mq.size() != 2); end
            if (mq.size() != 0) begin
               checks++;
               if ({out_domain_w[k], out_msg_w[k], out_route_w[k], out_err_w[k]} !== {mq[0].dom, mq[0].msg, mq[0].route[k], mq[0].err[k]}) begin
                  failures++;
                  $display("FAIL rnd_head i=%0d k=%0d got dom=%b msg=%h route=%b err=%b exp dom=%b msg=%h route=%b err=%b",
                           i, k, out_domain_w[k], out_msg_w[k], out_route_w[k], out_err_w[k],
                           mq[0].dom, mq[0].msg, mq[0].route[k], mq[0].err[k]);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench time limit reached");
   end

   initial begin
      test_reset();
      test_route();
      test_tie_domains();
      test_fixed_tie();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
